// File: rtl/demux_1_4_buf_pkg.sv
// Shared definitions for the 1:4 buffered demux: default widths, channel
// count, select encodings and the per-channel occupancy encoding.
package demux_1_4_buf_pkg;

  localparam int W_DEF  = 8;
  localparam int CW_DEF = 8;
  localparam int NCH    = 4;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  // One-hot channel decode of the select field.
  function automatic logic [NCH-1:0] sel_decode(input logic [1:0] sel);
    logic [NCH-1:0] oh;
    oh = '0;
    unique case (sel)
      CH0: oh = 4'b0001;
      CH1: oh = 4'b0010;
      CH2: oh = 4'b0100;
      CH3: oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// One output channel: 2-entry FIFO with a registered head word and a
// delivered-word counter.
//
// state     | meaning
// ----------+---------------------------------------------
// OCC_EMPTY | no word queued, dout holds the last head
// OCC_ONE   | head valid, tail unused
// OCC_TWO   | head and tail valid, channel full
module demux_chan_fifo
  import demux_1_4_buf_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  output logic          full,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] cnt
);

  occ_t          occ_q, occ_d;
  logic [W-1:0]  head_q, head_d;
  logic [W-1:0]  tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign valid   = (occ_q != OCC_EMPTY);
  assign full    = (occ_q == OCC_TWO);
  // A full channel refuses a push even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign dout    = head_q;
  assign cnt     = cnt_q;

  // Occupancy, head/tail and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next occupancy and data movement; head keeps its value when emptied.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = do_pop ? cnt_q + 1'b1 : cnt_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (do_push) begin
          head_d = din;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (do_push && do_pop) begin
          head_d = din;
        end else if (do_push) begin
          tail_d = din;
          occ_d  = OCC_TWO;
        end else if (do_pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (do_pop) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

endmodule

// File: rtl/demux_1_4_buf.sv
// 1:4 demux with a 2-entry buffer per output channel. The top level only
// decodes the select and muxes the per-channel full flags into in_ready;
// all storage lives in the channel FIFOs.
module demux_1_4_buf
  import demux_1_4_buf_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = 2,
  parameter int CW    = CW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      I,
  input  logic [1:0]        S,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [4*W-1:0]    Y,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [4*CW-1:0]   cnt
);

  // The channel FIFO is hand-built for exactly two entries.
  if (DEPTH != 2) begin : g_depth_chk
    $error("demux_1_4_buf supports DEPTH=2 only");
  end

  logic [NCH-1:0] full;
  logic [NCH-1:0] sel_oh;
  logic [NCH-1:0] push;

  assign sel_oh   = sel_decode(S);
  // No pop-through: readiness depends only on the addressed channel's fill.
  assign in_ready = !rst && !full[S];
  assign push     = {NCH{in_valid && in_ready}} & sel_oh;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    demux_chan_fifo #(
      .W  (W),
      .CW (CW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .din   (I),
      .full  (full[k]),
      .pop   (out_ready[k]),
      .dout  (Y[k*W +: W]),
      .valid (out_valid[k]),
      .cnt   (cnt[k*CW +: CW])
    );
  end

endmodule

// File: doc/demux_1_4_buf.md
Name: demux_1_4_buf

Overview:
- Inverse of the 4:1 selector: routes one input word stream to one of four output channels, chosen per word by a 2-bit select S.
- Each channel has a 2-entry buffer and its own valid/ready handshake, so a stalled output blocks only words addressed to it.
- Sits downstream of any single-source producer that feeds four consumers. Also provides per-channel delivered-word counters for debug.

Parameters:
- W, 8, data width in bits
- DEPTH, 2, entries per channel buffer (fixed at 2; other values are not supported)
- CW, 8, width of each delivered-word counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- I  input  W  input data word
- S  input  2  destination channel for I (0..3)
- in_valid  input  1  I/S valid
- in_ready  output  1  block can accept the current word
- Y  output  4*W  channel data; channel k occupies Y[k*W +: W]
- out_valid  output  4  per-channel head entry valid
- out_ready  input  4  per-channel consumer ready
- cnt  output  4*CW  per-channel delivered-word count; channel k occupies cnt[k*CW +: CW]

Behaviour:
- Reset: one synchronous cycle with rst=1 sets, at the next edge:
  - all buffers empty
  - out_valid=4'b0000, Y=0, cnt=0
  - in_ready is forced to 0 while rst=1
- Input accept: when in_valid && in_ready at a rising edge, I is written to the tail of buffer S.
  - in_ready = !full[S], combinational from S.
  - A full channel is never accepted into, even if it pops in the same cycle. There is no pop-through, so there is no out_ready->in_ready path.
- Output handshake, per channel k, independent of the other channels:
  - out_valid[k] = !empty[k].
  - Y[k] shows the head entry, registered.
  - Y[k] holds its previous value when the channel is empty.
  - A pop occurs on out_valid[k] && out_ready[k] at the edge.
- Latency: a word accepted at edge n is visible at that channel's output after edge n, provided the channel was empty. Otherwise it appears behind the entries already queued.
- Ordering: FIFO order is preserved within a channel. There is no ordering guarantee across channels.
- Buffer occupancy states per channel:
  - EMPTY -> ONE on push.
  - ONE -> TWO on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE stays ONE on simultaneous push and pop; the head updates to the new word.
  - TWO -> ONE on pop. Push is blocked in TWO.
- Counters:
  - cnt[k] increments by 1 on each pop of channel k.
  - Wraps modulo 2^CW (255 -> 0 for CW=8). No saturation.
- Invalid conditions:
  - in_valid=0: S and I are ignored, and no state changes.
  - S may change every cycle.
  - out_ready is ignored while out_valid=0; no counter change occurs.
- Reset mid-operation: queued words are discarded, with no flush handshake. Counters clear.
- Data-independent: X on I while in_valid=0 must not propagate into any state.

Decomposition:
- Shared include header holds:
  - default W/CW
  - channel count constant NCH=4
  - select encodings CH0..CH3 (2'd0..2'd3)
- Sub-module demux_chan_fifo: 2-entry FIFO (clk, rst, push, din, full, pop, dout, valid) plus its CW counter. Instantiated 4 times via generate.
- Top level: select decode and in_ready mux only.

Test Plan:
- Reset with out_ready=4'b1111: after rst, check out_valid=0, cnt=0, and in_ready=1 for every S value.
- Route one word: I=8'hA5, S=2, in_valid=1 for one cycle, out_ready=4'b1111.
  - Next cycle: out_valid=4'b0100 and Y[23:16]=8'hA5.
  - Cycle after: out_valid=0 and cnt[2]=1.
- Backpressure: out_ready[1]=0; send 3 words to S=1 (11,22,33).
  - After 2 accepts, in_ready=0 while S=1, but in_ready=1 for S=0.
  - Raise out_ready[1]: words pop in order 11,22,33 and cnt[1] ends at 3.
- Cross-channel independence: channel 3 stalled and full, then stream S=0 words every cycle.
  - Channel 0 accepts and delivers 1 word/cycle, with no effect on channel 3 contents.
- Simultaneous push/pop in state ONE, and counter wrap:
  - Push/pop in ONE: occupancy stays ONE and the new head is correct.
  - Wrap: 256 pops on channel 0 give cnt[0]=0.
- Mid-stream reset: with channels holding 2 and 1 words, assert rst for one cycle.
  - All out_valid drop to 0 and cnt=0.
  - Subsequent words route normally.
